// File: rtl/dma_multich.sv
// Multi-channel memory-to-memory DMA engine for the X16 6502 expansion bus.
// CPU programs channels through a register window, then GO halts the CPU while active channels run round-robin.
module dma_multich #(
    parameter int NCH   = 4,
    parameter int CW    = 16,
    parameter int BURST = 1
) (
    input  logic        PHI2,
    input  logic        RST,
    input  logic        CS,
    input  logic        RWB_I,
    input  logic [15:0] ADDR_I,
    input  logic [7:0]  DATA_I,
    output logic        HALT,
    output logic        BUS_OE,
    output logic [15:0] ADDR_O,
    output logic        RWB_O,
    output logic        DATA_OE,
    output logic [7:0]  DATA_O,
    output logic        IRQ
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    // Handshake: the engine owns the bus whenever state_q != S_IDLE; HALT,
    // BUS_OE and DATA_OE are pure decodes of state_q, so CPU access only
    // happens in S_IDLE and every DMA bus cycle lasts exactly one PHI2 period.
    state_t         state_q, state_d;
    logic [CHW-1:0] cur_q, cur_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [7:0]     byte_buf;

    logic [15:0]    sadd [NCH];
    logic [15:0]    sinc [NCH];
    logic [15:0]    dadd [NCH];
    logic [15:0]    dinc [NCH];
    logic [CW-1:0]  count [NCH];
    logic [7:0]     fillbyte [NCH];
    logic [NCH-1:0] arm, fill, ien, done, active;

    logic [CHW-1:0] ch_sel, cur_inc;
    logic           ch_ok, cpu_we, go_we, last_byte, burst_end;
    logic [3:0]     off;
    logic [NCH-1:0] go_mask, rem_mask;
    logic [7:0]     bcnt_nx, rd_data;
    logic [15:0]    cnt_sel16, cnt_lo_w, cnt_hi_w;
    logic           unused_bits;

    function automatic logic [15:0] zext(input logic [CW-1:0] v);
        logic [15:0] r;
        r = '0;
        r[CW-1:0] = v;
        return r;
    endfunction

    // Lowest set bit of mask at or after start, wrapping around the channel ring.
    function automatic logic [CHW-1:0] pick(input logic [NCH-1:0] mask, input logic [CHW-1:0] start);
        logic [CHW-1:0] r;
        logic           hit;
        int             idx;
        r   = '0;
        hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(start) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!hit && mask[CHW'(idx)]) begin
                r   = CHW'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    assign unused_bits = ^ADDR_I[15:4];
    assign off     = ADDR_I[3:0];
    assign ch_sel  = (NCH == 1) ? '0 : ADDR_I[4 +: CHW];
    assign ch_ok   = (int'(ch_sel) < NCH);
    assign cpu_we  = CS && !RWB_I && (state_q == S_IDLE);
    assign go_we   = cpu_we && (off == 4'hF);
    assign cur_inc = (cur_q == CHW'(NCH - 1)) ? '0 : cur_q + 1'b1;
    assign last_byte = (count[cur_q] == CW'(1));
    assign bcnt_nx   = bcnt_q + 8'd1;
    assign burst_end = last_byte || (bcnt_nx == 8'(BURST));
    assign IRQ       = |(done & ien);

    always_comb begin
        go_mask  = '0;
        rem_mask = '0;
        for (int c = 0; c < NCH; c++) begin
            go_mask[CHW'(c)]  = arm[CHW'(c)] && (count[CHW'(c)] != '0);
            rem_mask[CHW'(c)] = active[CHW'(c)] && !(last_byte && (CHW'(c) == cur_q));
        end
    end

    always_comb begin
        cnt_sel16 = ch_ok ? zext(count[ch_sel]) : 16'h0000;
        cnt_lo_w  = {cnt_sel16[15:8], DATA_I};
        cnt_hi_w  = {DATA_I, cnt_sel16[7:0]};
    end

    always_ff @(posedge PHI2) begin
        if (RST) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            S_IDLE: begin
                if (go_we && (|go_mask)) begin
                    cur_d   = pick(go_mask, '0);
                    bcnt_d  = '0;
                    state_d = fill[cur_d] ? S_WR : S_RD;
                end
            end
            S_RD: state_d = S_WR;
            S_WR: begin
                if (burst_end) begin
                    bcnt_d = '0;
                    if (|rem_mask) begin
                        cur_d   = pick(rem_mask, cur_inc);
                        state_d = fill[cur_d] ? S_WR : S_RD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bcnt_d  = bcnt_nx;
                    state_d = fill[cur_q] ? S_WR : S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PHI2) begin
        if (RST) begin
            for (int c = 0; c < NCH; c++) begin
                sadd[CHW'(c)]     <= '0;
                sinc[CHW'(c)]     <= '0;
                dadd[CHW'(c)]     <= '0;
                dinc[CHW'(c)]     <= '0;
                count[CHW'(c)]    <= '0;
                fillbyte[CHW'(c)] <= '0;
            end
            arm      <= '0;
            fill     <= '0;
            ien      <= '0;
            done     <= '0;
            active   <= '0;
            byte_buf <= '0;
        end else begin
            if (go_we) begin
                for (int c = 0; c < NCH; c++) begin
                    if (arm[CHW'(c)]) begin
                        arm[CHW'(c)] <= 1'b0;
                        if (count[CHW'(c)] == '0) done[CHW'(c)]   <= 1'b1;
                        else                      active[CHW'(c)] <= 1'b1;
                    end
                end
            end else if (cpu_we && ch_ok) begin
                case (off)
                    4'h0: sadd[ch_sel][7:0]  <= DATA_I;
                    4'h1: sadd[ch_sel][15:8] <= DATA_I;
                    4'h2: sinc[ch_sel][7:0]  <= DATA_I;
                    4'h3: sinc[ch_sel][15:8] <= DATA_I;
                    4'h4: dadd[ch_sel][7:0]  <= DATA_I;
                    4'h5: dadd[ch_sel][15:8] <= DATA_I;
                    4'h6: dinc[ch_sel][7:0]  <= DATA_I;
                    4'h7: dinc[ch_sel][15:8] <= DATA_I;
                    4'h8: count[ch_sel] <= cnt_lo_w[CW-1:0];
                    4'h9: count[ch_sel] <= cnt_hi_w[CW-1:0];
                    4'hA: begin
                        arm[ch_sel]  <= DATA_I[0];
                        fill[ch_sel] <= DATA_I[1];
                        ien[ch_sel]  <= DATA_I[2];
                        if (DATA_I[3]) done[ch_sel] <= 1'b0;
                    end
                    4'hB: fillbyte[ch_sel] <= DATA_I;
                    default: ;
                endcase
            end

            if (state_q == S_RD) begin
                byte_buf     <= DATA_I;
                sadd[cur_q]  <= sadd[cur_q] + sinc[cur_q];
            end
            if (state_q == S_WR) begin
                dadd[cur_q]  <= dadd[cur_q] + dinc[cur_q];
                count[cur_q] <= count[cur_q] - CW'(1);
                if (last_byte) begin
                    active[cur_q] <= 1'b0;
                    done[cur_q]   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (ch_ok) begin
            case (off)
                4'h0: rd_data = sadd[ch_sel][7:0];
                4'h1: rd_data = sadd[ch_sel][15:8];
                4'h2: rd_data = sinc[ch_sel][7:0];
                4'h3: rd_data = sinc[ch_sel][15:8];
                4'h4: rd_data = dadd[ch_sel][7:0];
                4'h5: rd_data = dadd[ch_sel][15:8];
                4'h6: rd_data = dinc[ch_sel][7:0];
                4'h7: rd_data = dinc[ch_sel][15:8];
                4'h8: rd_data = cnt_sel16[7:0];
                4'h9: rd_data = cnt_sel16[15:8];
                4'hA: rd_data = {3'b000, active[ch_sel], done[ch_sel], ien[ch_sel], fill[ch_sel], arm[ch_sel]};
                4'hB: rd_data = fillbyte[ch_sel];
                default: rd_data = '0;
            endcase
        end
    end

    always_comb begin
        HALT    = (state_q != S_IDLE);
        BUS_OE  = (state_q != S_IDLE);
        ADDR_O  = '0;
        RWB_O   = 1'b1;
        DATA_OE = 1'b0;
        DATA_O  = '0;
        case (state_q)
            S_RD: ADDR_O = sadd[cur_q];
            S_WR: begin
                ADDR_O  = dadd[cur_q];
                RWB_O   = 1'b0;
                DATA_OE = 1'b1;
                DATA_O  = fill[cur_q] ? fillbyte[cur_q] : byte_buf;
            end
            default: begin
                if (CS && RWB_I) begin
                    DATA_OE = 1'b1;
                    DATA_O  = rd_data;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_dma_multich.sv
// Bench for dma_multich: directed and randomized channel programs checked against a
// transfer-level model that schedules bytes and predicts every bus cycle and register.
module tb_dma_multich;
    localparam int NCH   = 4;
    localparam int CW    = 16;
    localparam int BURST = 1;

    logic        PHI2 = 1'b0;
    logic        RST, CS, RWB_I;
    logic [15:0] ADDR_I;
    logic [7:0]  DATA_I;
    logic        HALT, BUS_OE, RWB_O, DATA_OE, IRQ;
    logic [15:0] ADDR_O;
    logic [7:0]  DATA_O;

    dma_multich #(.NCH(NCH), .CW(CW), .BURST(BURST)) dut (
        .PHI2(PHI2), .RST(RST), .CS(CS), .RWB_I(RWB_I), .ADDR_I(ADDR_I), .DATA_I(DATA_I),
        .HALT(HALT), .BUS_OE(BUS_OE), .ADDR_O(ADDR_O), .RWB_O(RWB_O),
        .DATA_OE(DATA_OE), .DATA_O(DATA_O), .IRQ(IRQ)
    );

    // clock / reset
    always #5 PHI2 = ~PHI2;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]     mem  [65536];
    logic [7:0]     mmem [65536];
    logic [15:0]    m_sadd [NCH];
    logic [15:0]    m_sinc [NCH];
    logic [15:0]    m_dadd [NCH];
    logic [15:0]    m_dinc [NCH];
    int             m_cnt  [NCH];
    logic [7:0]     m_fb   [NCH];
    logic [NCH-1:0] m_arm, m_fill, m_ien, m_done;

    // bus cycle record: {BUS_OE, DATA_OE, RWB_O, addr, data}
    logic [26:0]    exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sadd[c] = '0; m_sinc[c] = '0; m_dadd[c] = '0; m_dinc[c] = '0;
            m_cnt[c] = 0; m_fb[c] = '0;
        end
        m_arm = '0; m_fill = '0; m_ien = '0; m_done = '0;
    endtask

    function automatic logic [7:0] m_ctrl(input int c);
        return {4'b0000, m_done[c], m_ien[c], m_fill[c], m_arm[c]};
    endfunction

    // driver tasks
    task automatic cpu_write(input int ch, input int off, input logic [7:0] d);
        @(negedge PHI2);
        CS = 1'b1; RWB_I = 1'b0; ADDR_I = 16'(ch * 16 + off); DATA_I = d;
        @(negedge PHI2);
        CS = 1'b0; RWB_I = 1'b1; ADDR_I = '0; DATA_I = '0;
    endtask

    task automatic wr_reg(input int ch, input int off, input logic [7:0] d);
        cpu_write(ch, off, d);
        case (off)
            0: m_sadd[ch][7:0]  = d;
            1: m_sadd[ch][15:8] = d;
            2: m_sinc[ch][7:0]  = d;
            3: m_sinc[ch][15:8] = d;
            4: m_dadd[ch][7:0]  = d;
            5: m_dadd[ch][15:8] = d;
            6: m_dinc[ch][7:0]  = d;
            7: m_dinc[ch][15:8] = d;
            8: m_cnt[ch] = (m_cnt[ch] & 32'hFF00) | int'(d);
            9: m_cnt[ch] = (m_cnt[ch] & 32'h00FF) | (int'(d) << 8);
            10: begin
                m_arm[ch] = d[0]; m_fill[ch] = d[1]; m_ien[ch] = d[2];
                if (d[3]) m_done[ch] = 1'b0;
            end
            11: m_fb[ch] = d;
            default: ;
        endcase
    endtask

    task automatic prog(input int ch, input logic [15:0] sa, input logic [15:0] si,
                        input logic [15:0] da, input logic [15:0] di, input logic [15:0] cnt,
                        input logic [7:0] ctrl, input logic [7:0] fb);
        wr_reg(ch, 0, sa[7:0]);  wr_reg(ch, 1, sa[15:8]);
        wr_reg(ch, 2, si[7:0]);  wr_reg(ch, 3, si[15:8]);
        wr_reg(ch, 4, da[7:0]);  wr_reg(ch, 5, da[15:8]);
        wr_reg(ch, 6, di[7:0]);  wr_reg(ch, 7, di[15:8]);
        wr_reg(ch, 8, cnt[7:0]); wr_reg(ch, 9, cnt[15:8]);
        wr_reg(ch, 11, fb);
        wr_reg(ch, 10, ctrl);
    endtask

    task automatic chk_reg(input string tag, input int ch, input int off, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        @(negedge PHI2);
        CS = 1'b1; RWB_I = 1'b1; ADDR_I = 16'(ch * 16 + off);
        #1;
        d = DATA_O; oe = DATA_OE;
        CS = 1'b0; ADDR_I = '0;
        check(tag, {oe, d}, {1'b1, exp});
    endtask

    task automatic chk_idle(input string tag);
        check(tag, {HALT, BUS_OE, DATA_OE, RWB_O, ADDR_O, DATA_O, IRQ}, {4'b0001, 16'h0000, 8'h00, 1'b0});
    endtask

    task automatic chk_all_regs(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk_reg({tag, "_sadd_lo"}, c, 0, m_sadd[c][7:0]);
            chk_reg({tag, "_sadd_hi"}, c, 1, m_sadd[c][15:8]);
            chk_reg({tag, "_dadd_lo"}, c, 4, m_dadd[c][7:0]);
            chk_reg({tag, "_dadd_hi"}, c, 5, m_dadd[c][15:8]);
            chk_reg({tag, "_cnt_lo"}, c, 8, 8'(m_cnt[c]));
            chk_reg({tag, "_ctrl"}, c, 10, m_ctrl(c));
        end
    endtask

    // Reference: GO semantics, then byte-by-byte round-robin schedule of all active channels.
    task automatic build_expect();
        logic [NCH-1:0] act;
        logic [7:0]     dat;
        int             ptr, ch;
        act = '0;
        for (int c = 0; c < NCH; c++) begin
            if (m_arm[c]) begin
                if (m_cnt[c] == 0) m_done[c] = 1'b1;
                else               act[c] = 1'b1;
                m_arm[c] = 1'b0;
            end
        end
        ptr = 0;
        while (|act) begin
            ch = -1;
            for (int k = 0; k < NCH; k++)
                if (ch < 0 && act[(ptr + k) % NCH]) ch = (ptr + k) % NCH;
            for (int b = 0; b < BURST && m_cnt[ch] > 0; b++) begin
                if (!m_fill[ch]) begin
                    dat = mmem[m_sadd[ch]];
                    exp_q.push_back({1'b1, 1'b0, 1'b1, m_sadd[ch], dat});
                    m_sadd[ch] = m_sadd[ch] + m_sinc[ch];
                end else begin
                    dat = m_fb[ch];
                end
                exp_q.push_back({1'b1, 1'b1, 1'b0, m_dadd[ch], dat});
                mmem[m_dadd[ch]] = dat;
                m_dadd[ch] = m_dadd[ch] + m_dinc[ch];
                m_cnt[ch]  = m_cnt[ch] - 1;
            end
            if (m_cnt[ch] == 0) begin
                act[ch] = 1'b0;
                m_done[ch] = 1'b1;
            end
            ptr = (ch + 1) % NCH;
        end
    endtask

    // GO, then follow the bus; poke_kind 1 = CPU write, 2 = CPU read of CTRL during busy cycle poke_cyc.
    task automatic run_go(input string tag, input int poke_cyc, input int poke_kind);
        logic [26:0] got, e;
        int          n_exp, cyc;
        cpu_write(0, 15, 8'($urandom));
        build_expect();
        n_exp = exp_q.size();
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == poke_cyc && poke_kind != 0) begin
                CS = 1'b1; RWB_I = (poke_kind == 2);
                ADDR_I = (poke_kind == 2) ? 16'h003A : 16'h0030;
                DATA_I = 8'h55;
            end else if (i == poke_cyc + 1) begin
                CS = 1'b0; RWB_I = 1'b1; ADDR_I = '0;
            end
            #1;
            if (!HALT) break;
            cyc++;
            if (BUS_OE && RWB_O) begin
                DATA_I = mem[ADDR_O];
                got = {BUS_OE, DATA_OE, RWB_O, ADDR_O, mem[ADDR_O]};
            end else begin
                got = {BUS_OE, DATA_OE, RWB_O, ADDR_O, DATA_O};
                if (BUS_OE) mem[ADDR_O] = DATA_O;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check({tag, "_bus"}, 32'(got), 32'(e));
            @(negedge PHI2);
        end
        CS = 1'b0; RWB_I = 1'b1; ADDR_I = '0; DATA_I = '0;
        check({tag, "_halt_cycles"}, cyc, n_exp);
        check({tag, "_released"}, {HALT, BUS_OE, DATA_OE}, 3'b000);
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] incs [4];
        RST = 1'b1; CS = 1'b0; RWB_I = 1'b1; ADDR_I = '0; DATA_I = '0;
        for (int a = 0; a < 65536; a++) begin
            mem[a]  = 8'($urandom);
            mmem[a] = mem[a];
        end
        model_reset();
        repeat (3) @(negedge PHI2);
        RST = 1'b0;
        #1;
        chk_idle("reset_outputs");
        chk_reg("reset_sadd", 0, 0, 8'h00);
        chk_reg("reset_ctrl", 0, 10, 8'h00);
        chk_reg("unmapped_off", 2, 12, 8'h00);

        // straight copy, three bytes
        prog(0, 16'h1000, 16'h0001, 16'h2000, 16'h0001, 16'd3, 8'h09, 8'h00);
        run_go("copy3", -1, 0);
        chk_reg("copy3_sadd_lo", 0, 0, 8'h03);
        chk_reg("copy3_sadd_hi", 0, 1, 8'h10);
        chk_reg("copy3_cnt_lo", 0, 8, 8'h00);
        chk_reg("copy3_ctrl", 0, 10, 8'h08);

        // fill across the FFFF->0000 wrap with IRQ
        prog(0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0001, 16'd4, 8'h0F, 8'hAA);
        #1 check("fill_irq_before", IRQ, 1'b0);
        run_go("fill_wrap", -1, 0);
        #1 check("fill_irq_after", IRQ, 1'b1);
        chk_reg("fill_dadd_hi", 0, 5, 8'h00);
        wr_reg(0, 10, 8'h0C);
        #1 check("fill_irq_cleared", IRQ, |(m_done & m_ien));

        // two channels interleaved, channel 2 walking its source downwards
        prog(0, 16'h3000, 16'h0001, 16'h4000, 16'h0001, 16'd2, 8'h09, 8'h00);
        prog(2, 16'h5000, 16'hFFFF, 16'h6000, 16'h0001, 16'd2, 8'h09, 8'h00);
        run_go("interleave", -1, 0);
        chk_reg("interleave_ch2_sadd_lo", 2, 0, 8'hFE);
        chk_reg("interleave_ch2_sadd_hi", 2, 1, 8'h4F);

        // zero count completes without touching the bus
        prog(1, 16'h0100, 16'h0001, 16'h0200, 16'h0001, 16'd0, 8'h09, 8'h00);
        run_go("zero_count", -1, 0);
        chk_reg("zero_count_ctrl", 1, 10, 8'h08);

        // CPU write ignored while busy, CPU read does not steal the data bus
        prog(3, 16'h7000, 16'h0001, 16'h7100, 16'h0001, 16'd6, 8'h09, 8'h00);
        run_go("busy_wr", 2, 1);
        chk_reg("busy_wr_sadd_lo", 3, 0, m_sadd[3][7:0]);
        prog(3, 16'h7200, 16'h0001, 16'h7300, 16'h0002, 16'd3, 8'h09, 8'h00);
        run_go("busy_rd_rd", 0, 2);
        prog(3, 16'h7400, 16'h0001, 16'h7500, 16'h0001, 16'd3, 8'h09, 8'h00);
        run_go("busy_rd_wr", 1, 2);

        // randomized channel programs
        incs[0] = 16'h0000; incs[1] = 16'h0001; incs[2] = 16'hFFFF;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < NCH; c++) begin
                incs[3] = 16'($urandom);
                prog(c, 16'($urandom), incs[$urandom_range(0, 3)], 16'($urandom), incs[$urandom_range(0, 3)],
                     16'($urandom_range(0, 5)), {1'b1, 1'($urandom), 1'($urandom), 1'($urandom)}, 8'($urandom));
            end
            run_go("rand", -1, 0);
            chk_all_regs("rand");
            #1 check("rand_irq", IRQ, |(m_done & m_ien));
        end

        // reset in the middle of a write cycle
        prog(1, 16'h7800, 16'h0001, 16'h7900, 16'h0001, 16'd5, 8'h0D, 8'h00);
        cpu_write(0, 15, 8'h00);
        @(negedge PHI2);
        #1 check("rst_pre_wr", {HALT, RWB_O}, 2'b10);
        RST = 1'b1;
        @(negedge PHI2);
        #1 chk_idle("rst_mid_outputs");
        RST = 1'b0;
        model_reset();
        @(negedge PHI2);
        #1 chk_idle("rst_no_resume");
        chk_all_regs("rst_regs");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
